// File: rtl/risk_cache_pkg.sv
// Shared types for the risk-limit cache: request opcodes, controller states,
// the default-width {max, acc} entry layout and a saturating counter helper.
package risk_cache_pkg;

  localparam int unsigned AMT_W_DEF = 16;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_SET_MAX   = 2'd1,
    OP_ADD_ORDER = 2'd2,
    OP_RSVD      = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_WRITE_BACK = 3'd2,
    S_ALLOCATE   = 3'd3,
    S_RESP       = 3'd4
  } state_e;

  // Entry layout at the default amount width; the cache redeclares it at its own AMT_W
  typedef struct packed {
    logic [AMT_W_DEF-1:0] max;
    logic [AMT_W_DEF-1:0] acc;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/risk_cache_store.sv
// Direct-mapped line storage: valid/dirty/tag/entry arrays with one
// combinational read port and one synchronous write port.
module risk_cache_store #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned ENT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  output logic [ENT_W-1:0] rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_dirty,
  input  logic [ENT_W-1:0] wr_entry
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [ENT_W-1:0] ent_q [LINES];

  // Only the status bits need clearing; tag/entry are qualified by valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      ent_q[wr_idx] <= wr_entry;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_entry = ent_q[rd_idx];

endmodule

// File: rtl/risk_limit_cache.sv
// Write-back cache of per-client risk limits {max, acc}: applies READ,
// SET_MAX and ADD_ORDER with limit checking, backed by a simple memory port.
module risk_limit_cache
  import risk_cache_pkg::*;
#(
  parameter int unsigned CLIENT_W = 12,
  parameter int unsigned LINES    = 16,
  parameter int unsigned AMT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [1:0]            cpu_req_op,
  input  logic [CLIENT_W-1:0]   cpu_req_client,
  input  logic [AMT_W-1:0]      cpu_req_amt,
  output logic                  cpu_res_valid,
  output logic [2*AMT_W-1:0]    cpu_res_entry,
  output logic                  cpu_res_reject,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [CLIENT_W-1:0]   mem_req_addr,
  output logic [2*AMT_W-1:0]    mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [2*AMT_W-1:0]    mem_rsp_data,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      reject_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = CLIENT_W - IDX_W;
  localparam int unsigned ENT_W = 2 * AMT_W;

  typedef struct packed {
    logic [AMT_W-1:0] max;
    logic [AMT_W-1:0] acc;
  } line_entry_t;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CLIENT_W-1:0]  client_q, client_d;
  logic [AMT_W-1:0]     amt_q, amt_d;
  logic                 mem_wait_q, mem_wait_d;
  logic                 res_valid_d, res_reject_d;
  logic [ENT_W-1:0]     res_entry_d;
  logic                 mreq_valid_d, mreq_rw_d;
  logic [CLIENT_W-1:0]  mreq_addr_d;
  logic [ENT_W-1:0]     mreq_data_d;
  logic [CNT_W-1:0]     hit_d, miss_d, reject_d;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]     rd_tag;
  logic [ENT_W-1:0]     rd_entry;
  logic                 wr_en, wr_dirty;
  logic [ENT_W-1:0]     wr_entry;
  line_entry_t          cur, upd;
  logic [AMT_W:0]       sum;
  logic                 add_reject;

  assign idx = client_q[IDX_W-1:0];
  assign tag = client_q[CLIENT_W-1:IDX_W];
  assign hit = rd_valid && (rd_tag == tag);
  assign cur = line_entry_t'(rd_entry);
  assign sum = (AMT_W+1)'(cur.acc) + (AMT_W+1)'(amt_q);
  // max == 0 means no limit has been set: only zero-amount orders pass
  assign add_reject = (cur.max == '0) ? (amt_q != '0) : (sum > (AMT_W+1)'(cur.max));

  assign cpu_req_ready = (state_q == S_IDLE) && !rst;

  risk_cache_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .ENT_W (ENT_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_entry (rd_entry),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_dirty (wr_dirty),
    .wr_entry (wr_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= OP_READ;
      client_q       <= '0;
      amt_q          <= '0;
      mem_wait_q     <= 1'b0;
      cpu_res_valid  <= 1'b0;
      cpu_res_entry  <= '0;
      cpu_res_reject <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      reject_cnt     <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      client_q       <= client_d;
      amt_q          <= amt_d;
      mem_wait_q     <= mem_wait_d;
      cpu_res_valid  <= res_valid_d;
      cpu_res_entry  <= res_entry_d;
      cpu_res_reject <= res_reject_d;
      mem_req_valid  <= mreq_valid_d;
      mem_req_rw     <= mreq_rw_d;
      mem_req_addr   <= mreq_addr_d;
      mem_req_data   <= mreq_data_d;
      hit_cnt        <= hit_d;
      miss_cnt       <= miss_d;
      reject_cnt     <= reject_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    client_d     = client_q;
    amt_d        = amt_q;
    mem_wait_d   = mem_wait_q;
    res_valid_d  = 1'b0;
    res_entry_d  = cpu_res_entry;
    res_reject_d = cpu_res_reject;
    mreq_valid_d = mem_req_valid;
    mreq_rw_d    = mem_req_rw;
    mreq_addr_d  = mem_req_addr;
    mreq_data_d  = mem_req_data;
    hit_d        = hit_cnt;
    miss_d       = miss_cnt;
    reject_d     = reject_cnt;
    wr_en        = 1'b0;
    wr_dirty     = 1'b0;
    wr_entry     = mem_rsp_data;
    upd          = cur;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          op_d     = op_e'(cpu_req_op);
          client_d = cpu_req_client;
          amt_d    = cpu_req_amt;
          state_d  = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (hit) begin
          hit_d        = sat_inc(hit_cnt);
          res_reject_d = 1'b0;
          unique case (op_q)
            OP_SET_MAX: begin
              upd.max  = amt_q;
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
            end
            OP_ADD_ORDER: begin
              if (add_reject) begin
                res_reject_d = 1'b1;
                reject_d     = sat_inc(reject_cnt);
              end else begin
                upd.acc  = sum[AMT_W-1:0];
                wr_en    = 1'b1;
                wr_dirty = 1'b1;
              end
            end
            default: ;
          endcase
          wr_entry    = ENT_W'(upd);
          res_entry_d = ENT_W'(upd);
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          miss_d       = sat_inc(miss_cnt);
          mreq_valid_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            mreq_rw_d   = 1'b1;
            mreq_addr_d = {rd_tag, idx};
            mreq_data_d = rd_entry;
            state_d     = S_WRITE_BACK;
          end else begin
            mreq_rw_d   = 1'b0;
            mreq_addr_d = client_q;
            state_d     = S_ALLOCATE;
          end
        end
      end

      // Victim write-back; the ack launches the line fill
      S_WRITE_BACK: begin
        if (mem_req_valid && mem_req_ready) begin
          mreq_valid_d = 1'b0;
          mem_wait_d   = 1'b1;
        end else if (mem_wait_q && mem_rsp_valid) begin
          mem_wait_d   = 1'b0;
          mreq_valid_d = 1'b1;
          mreq_rw_d    = 1'b0;
          mreq_addr_d  = client_q;
          state_d      = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        if (mem_req_valid && mem_req_ready) begin
          mreq_valid_d = 1'b0;
          mem_wait_d   = 1'b1;
        end else if (mem_wait_q && mem_rsp_valid) begin
          mem_wait_d = 1'b0;
          wr_en      = 1'b1;
          wr_dirty   = 1'b0;
          wr_entry   = mem_rsp_data;
          state_d    = S_COMPARE;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risk_limit_cache.sv
// Directed bench for risk_limit_cache with a small backing-memory responder.
module tb_risk_limit_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [1:0]  cpu_req_op;
  logic [11:0] cpu_req_client;
  logic [15:0] cpu_req_amt;
  logic        cpu_res_valid;
  logic [31:0] cpu_res_entry;
  logic        cpu_res_reject;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_rw;
  logic [11:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic [15:0] hit_cnt, miss_cnt, reject_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:4095];
  logic        ready_en;
  int          stray_req = 0;
  int          stray_done = 0;
  logic        rsp_pending = 1'b0;
  logic [31:0] rsp_data_p = 32'h0;
  logic        log_rw   [0:63];
  logic [11:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          log_n = 0;

  int          lat;
  logic [31:0] ent;
  logic        rej;
  int          n0;

  always #5 clk = ~clk;

  risk_limit_cache dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_op     (cpu_req_op),
    .cpu_req_client (cpu_req_client),
    .cpu_req_amt    (cpu_req_amt),
    .cpu_res_valid  (cpu_res_valid),
    .cpu_res_entry  (cpu_res_entry),
    .cpu_res_reject (cpu_res_reject),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .reject_cnt     (reject_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: handshake decided at negedge, response one cycle later
  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (rsp_pending) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp_data_p;
      rsp_pending   = 1'b0;
    end else if (stray_req != stray_done) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEADBEEF;
      stray_done    = stray_req;
    end
    mem_req_ready = ready_en;
    if (mem_req_valid && mem_req_ready) begin
      if (log_n < 64) begin
        log_rw[log_n]   = mem_req_rw;
        log_addr[log_n] = mem_req_addr;
        log_data[log_n] = mem_req_data;
        log_n++;
      end
      if (mem_req_rw) begin
        mem[mem_req_addr] = mem_req_data;
        rsp_data_p = 32'h0;
      end else begin
        rsp_data_p = mem[mem_req_addr];
      end
      rsp_pending = 1'b1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [11:0] client, input logic [15:0] amt);
    int n;
    @(negedge clk);
    cpu_req_valid  = 1'b1;
    cpu_req_op     = op;
    cpu_req_client = client;
    cpu_req_amt    = amt;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_req_ready) chk("req_accept_timeout", 64'(cpu_req_ready), 64'h1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_res(output int l, output logic [31:0] e, output logic r);
    l = 1;
    while (!cpu_res_valid && l < 300) begin
      @(negedge clk);
      l++;
    end
    if (!cpu_res_valid) chk("res_timeout", 64'(cpu_res_valid), 64'h1);
    e = cpu_res_entry;
    r = cpu_res_reject;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [11:0] client, input logic [15:0] amt,
                        output int l, output logic [31:0] e, output logic r);
    send(op, client, amt);
    wait_res(l, e, r);
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_valid) chk("mem_req_timeout", 64'(mem_req_valid), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_op     = 2'd0;
    cpu_req_client = 12'h0;
    cpu_req_amt    = 16'h0;
    ready_en       = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h026] = 32'h0050_0010;
    mem[12'h037] = 32'hFFFF_FFF0;

    repeat (3) @(negedge clk);
    chk("rst_ready",     64'(cpu_req_ready),  64'h0);
    chk("rst_res_valid", 64'(cpu_res_valid),  64'h0);
    chk("rst_entry",     64'(cpu_res_entry),  64'h0);
    chk("rst_mem_valid", 64'(mem_req_valid),  64'h0);
    chk("rst_counters",  64'({hit_cnt, miss_cnt, reject_cnt}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cpu_req_ready), 64'h1);

    // SET_MAX on a cold line: one fill read, then the update
    do_req(2'd1, 12'h005, 16'h0100, lat, ent, rej);
    chk("setmax_entry",   64'(ent), 64'h0100_0000);
    chk("setmax_reject",  64'(rej), 64'h0);
    chk("setmax_memreqs", 64'(log_n), 64'h1);
    chk("setmax_rd_rw",   64'(log_rw[0]), 64'h0);
    chk("setmax_rd_addr", 64'(log_addr[0]), 64'h005);
    chk("setmax_miss",    64'(miss_cnt), 64'h1);
    chk("setmax_hit",     64'(hit_cnt), 64'h1);

    do_req(2'd2, 12'h005, 16'h0080, lat, ent, rej);
    chk("add_lat",     64'(lat), 64'h2);
    chk("add_entry",   64'(ent), 64'h0100_0080);
    chk("add_reject",  64'(rej), 64'h0);
    chk("add_no_mem",  64'(log_n), 64'h1);

    do_req(2'd2, 12'h005, 16'h0081, lat, ent, rej);
    chk("addrej_lat",    64'(lat), 64'h2);
    chk("addrej_entry",  64'(ent), 64'h0100_0080);
    chk("addrej_reject", 64'(rej), 64'h1);
    chk("addrej_cnt",    64'(reject_cnt), 64'h1);

    // Conflict miss on a dirty line: write-back then fill
    do_req(2'd0, 12'h015, 16'h0000, lat, ent, rej);
    chk("evict_memreqs", 64'(log_n), 64'h3);
    chk("evict_wb_rw",   64'(log_rw[1]), 64'h1);
    chk("evict_wb_addr", 64'(log_addr[1]), 64'h005);
    chk("evict_wb_data", 64'(log_data[1]), 64'h0100_0080);
    chk("evict_rd_rw",   64'(log_rw[2]), 64'h0);
    chk("evict_rd_addr", 64'(log_addr[2]), 64'h015);
    chk("evict_entry",   64'(ent), 64'h0);
    chk("evict_miss",    64'(miss_cnt), 64'h2);
    chk("evict_hit",     64'(hit_cnt), 64'h4);

    // Memory stalls the fill request for 5 cycles
    ready_en = 1'b0;
    send(2'd0, 12'h026, 16'h0000);
    wait_mem_req();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(mem_req_valid), 64'h1);
      chk("stall_addr",  64'(mem_req_addr), 64'h026);
      chk("stall_rw",    64'(mem_req_rw), 64'h0);
      chk("stall_nores", 64'(cpu_res_valid), 64'h0);
    end
    ready_en = 1'b1;
    wait_res(lat, ent, rej);
    chk("stall_entry", 64'(ent), 64'h0050_0010);
    chk("stall_miss",  64'(miss_cnt), 64'h3);

    // Reset while a fill is outstanding, then a stray memory response
    ready_en = 1'b0;
    send(2'd0, 12'h005, 16'h0000);
    wait_mem_req();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("midrst_ready",     64'(cpu_req_ready), 64'h0);
    chk("midrst_miss",      64'(miss_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    ready_en = 1'b1;
    stray_req++;
    repeat (3) @(negedge clk);
    chk("stray_no_res",  64'(cpu_res_valid), 64'h0);
    chk("stray_no_mreq", 64'(mem_req_valid), 64'h0);
    chk("stray_ready",   64'(cpu_req_ready), 64'h1);
    do_req(2'd0, 12'h005, 16'h0000, lat, ent, rej);
    chk("postrst_entry",  64'(ent), 64'h0100_0080);
    chk("postrst_miss",   64'(miss_cnt), 64'h1);
    chk("postrst_hit",    64'(hit_cnt), 64'h1);
    chk("postrst_slow",   64'(lat > 2), 64'h1);
    chk("postrst_rdaddr", 64'(log_addr[log_n-1]), 64'h005);

    // Carry out of the accumulated sum must reject
    do_req(2'd2, 12'h037, 16'h0020, lat, ent, rej);
    chk("carry_reject", 64'(rej), 64'h1);
    chk("carry_entry",  64'(ent), 64'hFFFF_FFF0);
    chk("carry_cnt",    64'(reject_cnt), 64'h1);
    do_req(2'd0, 12'h037, 16'h0000, lat, ent, rej);
    chk("carry_read_lat",   64'(lat), 64'h2);
    chk("carry_read_entry", 64'(ent), 64'hFFFF_FFF0);

    // max == 0: zero amount passes, anything else is refused
    do_req(2'd2, 12'h048, 16'h0000, lat, ent, rej);
    chk("max0_zero_reject", 64'(rej), 64'h0);
    chk("max0_zero_entry",  64'(ent), 64'h0);
    do_req(2'd2, 12'h048, 16'h0001, lat, ent, rej);
    chk("max0_one_reject", 64'(rej), 64'h1);
    chk("max0_one_entry",  64'(ent), 64'h0);
    chk("max0_cnt",        64'(reject_cnt), 64'h2);

    do_req(2'd3, 12'h048, 16'h0005, lat, ent, rej);
    chk("rsvd_lat",    64'(lat), 64'h2);
    chk("rsvd_entry",  64'(ent), 64'h0);
    chk("rsvd_reject", 64'(rej), 64'h0);

    // Line 7 was only read or rejected, so eviction needs no write-back
    n0 = log_n;
    do_req(2'd0, 12'h017, 16'h0000, lat, ent, rej);
    chk("clean_memreqs", 64'(log_n), 64'(n0 + 1));
    chk("clean_rd_rw",   64'(log_rw[n0]), 64'h0);
    chk("clean_rd_addr", 64'(log_addr[n0]), 64'h017);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
